vector_mul_reduce: RTL and testbench

- Fixed-point vector engine for the backpropagation datapath.
- Takes two VECTOR_LEN operand vectors over independent valid/ready channels.
- Computes the elementwise (Hadamard) product and the dot-product sum in the same pass, processing TILING lanes per cycle.
- Adds configurable saturation, a wide reduction output and cross-transaction dot accumulation (gradient batching). The result feeds the weight-update and error-propagation stages.

---
 rtl/vector_pkg.sv | 38 +++
 rtl/vector_mul_lane.sv | 42 ++++
 rtl/vector_mul_reduce.sv | 166 ++++++++++++++++
 tb/tb_vector_mul_reduce.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_pkg
// Description : Shared state encoding and fixed-point helpers for vector_mul_reduce.
// Revision    : 1.0
// ============================================================================
package vector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Clamps value into a signed field of the given width when sat_en is set;
  // otherwise passes it through and the caller keeps only the low bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width,
                                                  input logic sat_en,
                                                  output logic ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    ovf = (value > hi) || (value < lo);
    if (ovf && sat_en) saturate = (value > hi) ? hi : lo;
    else saturate = value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_mul_lane.sv
`default_nettype none
// ============================================================================
// Module      : vector_mul_lane
// Description : One fixed-point lane: signed multiply, rescale, narrow with overflow flag.
// Revision    : 1.0
// ============================================================================
module vector_mul_lane
  import vector_pkg::*;
#(
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 4,
  parameter int SATURATE          = 1
) (
  input  logic [A_CELL_WIDTH-1:0]              a_i,
  input  logic [B_CELL_WIDTH-1:0]              b_i,
  output logic [A_CELL_WIDTH+B_CELL_WIDTH-1:0] prod_o,
  output logic [RESULT_CELL_WIDTH-1:0]         res_o,
  output logic                                 ovf_o
);

  localparam int PROD_W = A_CELL_WIDTH + B_CELL_WIDTH;

  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_b_ext;
  logic signed [PROD_W-1:0] w_full;
  logic signed [PROD_W-1:0] w_shift;

  assign w_a_ext = PROD_W'($signed(a_i));
  assign w_b_ext = PROD_W'($signed(b_i));
  assign w_full  = w_a_ext * w_b_ext;
  assign w_shift = w_full >>> FRACTION_WIDTH;
  assign prod_o  = w_shift;

  always_comb begin
    ovf_o = 1'b0;
    res_o = RESULT_CELL_WIDTH'(saturate(64'(w_shift), RESULT_CELL_WIDTH, SATURATE != 0, ovf_o));
  end

endmodule
`default_nettype wire

// File: rtl/vector_mul_reduce.sv
`default_nettype none
// ============================================================================
// Module      : vector_mul_reduce
// Description : Tiled Hadamard product plus accumulating dot product over two operand channels.
// Revision    : 1.0
// ============================================================================
module vector_mul_reduce
  import vector_pkg::*;
#(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int SUM_WIDTH         = 16,
  parameter int FRACTION_WIDTH    = 4,
  parameter int TILING            = 1,
  parameter int SATURATE          = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]        a_i,
  input  logic                                      a_acc_i,
  input  logic                                      a_valid_i,
  output logic                                      a_ready_o,
  input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]        b_i,
  input  logic                                      b_valid_i,
  output logic                                      b_ready_o,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0]   result_o,
  output logic [SUM_WIDTH-1:0]                      dot_o,
  output logic                                      result_valid_o,
  input  logic                                      result_ready_i,
  output logic                                      error_o
);

  localparam int CNT_W  = clog2(VECTOR_LEN + TILING);
  localparam int PROD_W = A_CELL_WIDTH + B_CELL_WIDTH;

  state_t                                  state_q;
  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a_q;
  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b_q;
  logic                                    acc_flag_q;
  logic                                    a_ready_q;
  logic                                    b_ready_q;
  logic                                    result_valid_q;
  logic                                    error_q;
  logic [CNT_W-1:0]                        cnt_q;
  logic signed [SUM_WIDTH-1:0]             dot_q;
  logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result_q;

  logic [CNT_W-1:0]             w_idx [TILING];
  logic [CNT_W-1:0]             w_sel [TILING];
  logic [PROD_W-1:0]            w_prod [TILING];
  logic [RESULT_CELL_WIDTH-1:0] w_res [TILING];
  logic [TILING-1:0]            w_lane_vld;
  logic [TILING-1:0]            w_ovf;
  logic signed [SUM_WIDTH-1:0]  w_sum;
  logic                         w_sum_ovf;
  logic                         w_add_ovf;
  logic                         w_last;

  // Lanes past the end of the vector are steered to element 0 and ignored.
  generate
    for (genvar t = 0; t < TILING; t++) begin : g_lane
      assign w_idx[t]      = cnt_q + CNT_W'(t);
      assign w_lane_vld[t] = w_idx[t] < CNT_W'(VECTOR_LEN);
      assign w_sel[t]      = w_lane_vld[t] ? w_idx[t] : '0;

      vector_mul_lane #(
        .A_CELL_WIDTH      (A_CELL_WIDTH),
        .B_CELL_WIDTH      (B_CELL_WIDTH),
        .RESULT_CELL_WIDTH (RESULT_CELL_WIDTH),
        .FRACTION_WIDTH    (FRACTION_WIDTH),
        .SATURATE          (SATURATE)
      ) u_lane (
        .a_i    (a_q[int'(w_sel[t])*A_CELL_WIDTH +: A_CELL_WIDTH]),
        .b_i    (b_q[int'(w_sel[t])*B_CELL_WIDTH +: B_CELL_WIDTH]),
        .prod_o (w_prod[t]),
        .res_o  (w_res[t]),
        .ovf_o  (w_ovf[t])
      );
    end
  endgenerate

  // Lanes are folded into the running sum in index order, range-checked after every add.
  always_comb begin
    w_sum     = dot_q;
    w_sum_ovf = 1'b0;
    w_add_ovf = 1'b0;
    for (int t = 0; t < TILING; t++) begin
      if (w_lane_vld[t]) begin
        w_sum = SUM_WIDTH'(saturate(64'(w_sum) + 64'($signed(w_prod[t])),
                                    SUM_WIDTH, SATURATE != 0, w_add_ovf));
        w_sum_ovf = w_sum_ovf | w_add_ovf;
      end
    end
  end

  assign w_last = (cnt_q + CNT_W'(TILING)) >= CNT_W'(VECTOR_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      acc_flag_q     <= 1'b0;
      a_ready_q      <= 1'b1;
      b_ready_q      <= 1'b1;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      cnt_q          <= '0;
      dot_q          <= '0;
      result_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_valid_i && a_ready_q) begin
            a_q        <= a_i;
            acc_flag_q <= a_acc_i;
            a_ready_q  <= 1'b0;
          end
          if (b_valid_i && b_ready_q) begin
            b_q       <= b_i;
            b_ready_q <= 1'b0;
          end
          if (!a_ready_q && !b_ready_q) begin
            state_q <= CALC;
            cnt_q   <= '0;
            error_q <= 1'b0;
            if (!acc_flag_q) dot_q <= '0;
          end
        end
        CALC: begin
          for (int t = 0; t < TILING; t++) begin
            if (w_lane_vld[t])
              result_q[int'(w_sel[t])*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] <= w_res[t];
          end
          dot_q   <= w_sum;
          error_q <= error_q | w_sum_ovf | (|(w_ovf & w_lane_vld));
          cnt_q   <= cnt_q + CNT_W'(TILING);
          if (w_last) begin
            state_q        <= DONE;
            result_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready_i) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            a_ready_q      <= 1'b1;
            b_ready_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ready_o      = a_ready_q;
  assign b_ready_o      = b_ready_q;
  assign result_o       = result_q;
  assign dot_o          = dot_q;
  assign result_valid_o = result_valid_q;
  assign error_o        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_mul_reduce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vector_mul_reduce
// Description : Scoreboard bench over three configurations (T1/sat, T2/sat, T1/wrap).
// Revision    : 1.0
// ============================================================================
module tb_vector_mul_reduce;

  localparam int N  = 5;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int RW = 8;
  localparam int SW = 16;
  localparam int FW = 4;
  localparam int ND = 3;

  localparam logic [N*AW-1:0] A_BASIC = {5{8'h10}};
  localparam logic [N*BW-1:0] B_BASIC = {8'h50, 8'h40, 8'h30, 8'h20, 8'h10};
  localparam logic [N*AW-1:0] A_SAT   = {8'h00, 8'h00, 8'h00, 8'hF0, 8'h40};
  localparam logic [N*BW-1:0] B_SAT   = {8'h00, 8'h00, 8'h00, 8'h70, 8'h40};
  localparam logic [N*AW-1:0] A_MAX   = {5{8'h7F}};

  typedef struct packed {
    logic [N*RW-1:0] res;
    logic [SW-1:0]   dot;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*AW-1:0] a;
  logic            a_acc;
  logic            a_valid;
  logic [N*BW-1:0] b;
  logic            b_valid;
  logic            result_ready;
  logic [ND-1:0]   a_ready, b_ready, result_valid, error;
  logic [N*RW-1:0] result [ND];
  logic [SW-1:0]   dot [ND];

  exp_t            sb [ND][$];
  exp_t            mon_e;
  int              model_acc [ND];
  int              lat [ND];
  logic [SW-1:0]   snap_dot [ND];
  logic [N*RW-1:0] snap_res [ND];
  logic            snap_err [ND];
  int              pass_cnt = 0;
  int              chk_cnt  = 0;

  vector_mul_reduce #(.VECTOR_LEN(N), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW), .RESULT_CELL_WIDTH(RW),
                      .SUM_WIDTH(SW), .FRACTION_WIDTH(FW), .TILING(1), .SATURATE(1)) u_dut0 (
    .clk(clk), .rst(rst), .a_i(a), .a_acc_i(a_acc), .a_valid_i(a_valid), .a_ready_o(a_ready[0]),
    .b_i(b), .b_valid_i(b_valid), .b_ready_o(b_ready[0]), .result_o(result[0]), .dot_o(dot[0]),
    .result_valid_o(result_valid[0]), .result_ready_i(result_ready), .error_o(error[0]));

  vector_mul_reduce #(.VECTOR_LEN(N), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW), .RESULT_CELL_WIDTH(RW),
                      .SUM_WIDTH(SW), .FRACTION_WIDTH(FW), .TILING(2), .SATURATE(1)) u_dut1 (
    .clk(clk), .rst(rst), .a_i(a), .a_acc_i(a_acc), .a_valid_i(a_valid), .a_ready_o(a_ready[1]),
    .b_i(b), .b_valid_i(b_valid), .b_ready_o(b_ready[1]), .result_o(result[1]), .dot_o(dot[1]),
    .result_valid_o(result_valid[1]), .result_ready_i(result_ready), .error_o(error[1]));

  vector_mul_reduce #(.VECTOR_LEN(N), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW), .RESULT_CELL_WIDTH(RW),
                      .SUM_WIDTH(SW), .FRACTION_WIDTH(FW), .TILING(1), .SATURATE(0)) u_dut2 (
    .clk(clk), .rst(rst), .a_i(a), .a_acc_i(a_acc), .a_valid_i(a_valid), .a_ready_o(a_ready[2]),
    .b_i(b), .b_valid_i(b_valid), .b_ready_o(b_ready[2]), .result_o(result[2]), .dot_o(dot[2]),
    .result_valid_o(result_valid[2]), .result_ready_i(result_ready), .error_o(error[2]));

  function automatic bit sat_of(input int d);
    return (d != 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: Q-format product per element, running dot with per-add range check.
  function automatic exp_t model(input logic [N*AW-1:0] av, input logic [N*BW-1:0] bv,
                                 input logic accf, input bit sat, inout int acc);
    exp_t        e;
    int          p;
    int          s;
    logic [7:0]  r8;
    logic [15:0] s16;
    e = '0;
    s = accf ? acc : 0;
    for (int i = 0; i < N; i++) begin
      p = ($signed(av[i*AW +: AW]) * $signed(bv[i*BW +: BW])) >>> FW;
      if (p > 127) begin
        e.err = 1'b1;
        r8 = sat ? 8'h7F : p[7:0];
      end else if (p < -128) begin
        e.err = 1'b1;
        r8 = sat ? 8'h80 : p[7:0];
      end else begin
        r8 = p[7:0];
      end
      e.res[i*RW +: RW] = r8;
      s = s + p;
      if (s > 32767 || s < -32768) begin
        e.err = 1'b1;
        if (sat) s = (s > 32767) ? 32767 : -32768;
        else begin
          s16 = s[15:0];
          s = $signed(s16);
        end
      end
    end
    acc   = s;
    e.dot = s[15:0];
    return e;
  endfunction

  task automatic push_exp(input logic [N*AW-1:0] av, input logic [N*BW-1:0] bv, input logic accf);
    for (int d = 0; d < ND; d++) sb[d].push_back(model(av, bv, accf, sat_of(d), model_acc[d]));
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst && result_valid[d] && result_ready) begin
        if (sb[d].size() == 0) begin
          check($sformatf("dut%0d_unexpected_result", d), 64'd1, 64'd0);
        end else begin
          mon_e = sb[d].pop_front();
          check($sformatf("dut%0d_result", d), 64'(result[d]), 64'(mon_e.res));
          check($sformatf("dut%0d_dot", d), 64'(dot[d]), 64'(mon_e.dot));
          check($sformatf("dut%0d_error", d), 64'(error[d]), 64'(mon_e.err));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(&a_ready && &b_ready) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(&a_ready && &b_ready)) check("idle_timeout", 64'({a_ready, b_ready}), 64'(6'h3F));
  endtask

  task automatic send(input logic [N*AW-1:0] av, input logic [N*BW-1:0] bv, input logic accf);
    wait_idle();
    a = av; b = bv; a_acc = accf;
    a_valid = 1'b1; b_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    push_exp(av, bv, accf);
  endtask

  // Counts edges from the completing operand handshake until each DUT shows result_valid.
  task automatic wait_all(input string tag);
    logic [ND-1:0] seen;
    seen = '0;
    for (int d = 0; d < ND; d++) lat[d] = -1;
    for (int n = 1; n <= 40 && seen != '1; n++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        if (!seen[d] && result_valid[d]) begin
          seen[d]     = 1'b1;
          lat[d]      = n;
          snap_dot[d] = dot[d];
          snap_res[d] = result[d];
          snap_err[d] = error[d];
        end
      end
    end
    if (seen != '1) check({tag, "_timeout"}, 64'(seen), 64'(3'b111));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    a = '0; b = '0; a_acc = 1'b0; a_valid = 1'b0; b_valid = 1'b0; result_ready = 1'b1;
    for (int d = 0; d < ND; d++) model_acc[d] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({a_ready, b_ready, result_valid, error}), 64'({3'b111, 3'b111, 6'b0}));
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset_dot%0d", d), 64'(dot[d]), 64'd0);
      check($sformatf("reset_result%0d", d), 64'(result[d]), 64'd0);
    end
    rst = 1'b0;

    send(A_BASIC, B_BASIC, 1'b0);
    wait_all("basic");
    check("basic_latency_t1", 64'(lat[0]), 64'd6);
    check("basic_latency_t2", 64'(lat[1]), 64'd4);
    check("basic_latency_wrap", 64'(lat[2]), 64'd6);
    check("basic_result_t1", 64'(snap_res[0]), 64'h50_40_30_20_10);
    check("basic_result_t2", 64'(snap_res[1]), 64'h50_40_30_20_10);
    check("basic_dot_t1", 64'(snap_dot[0]), 64'h00F0);
    check("basic_err_t2", 64'(snap_err[1]), 64'd0);

    send(A_SAT, B_SAT, 1'b0);
    wait_all("sat");
    check("sat_result_clamp", 64'(snap_res[0]), 64'h00_00_00_90_7F);
    check("sat_result_wrap", 64'(snap_res[2]), 64'h00_00_00_90_00);
    check("sat_dot", 64'(snap_dot[0]), 64'h0090);
    check("sat_err_clamp", 64'(snap_err[0]), 64'd1);
    check("sat_err_wrap", 64'(snap_err[2]), 64'd1);

    for (int k = 0; k < 8; k++) begin
      send(A_MAX, A_MAX, k != 0);
      wait_all("sum_ovf");
    end
    check("sum_ovf_dot_clamp", 64'(snap_dot[0]), 64'h7FFF);
    check("sum_ovf_dot_wrap", 64'(snap_dot[2]), 64'h9D80);
    check("sum_ovf_err", 64'(snap_err[0]), 64'd1);

    send(A_BASIC, B_BASIC, 1'b0);
    wait_all("acc0");
    check("acc0_dot", 64'(snap_dot[0]), 64'h00F0);
    check("acc0_err_cleared", 64'(snap_err[0]), 64'd0);
    send(A_BASIC, B_BASIC, 1'b1);
    wait_all("acc1");
    check("acc1_dot_t1", 64'(snap_dot[0]), 64'h01E0);
    check("acc1_dot_t2", 64'(snap_dot[1]), 64'h01E0);
    send(A_BASIC, B_BASIC, 1'b0);
    wait_all("acc2");
    check("acc2_dot", 64'(snap_dot[0]), 64'h00F0);

    for (int k = 0; k < 12; k++) begin
      send(40'({$urandom(), $urandom()}), 40'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
      wait_all("random");
    end

    // Backpressure: b arrives alone, a seven cycles later, consumer stalls in DONE.
    wait_idle();
    result_ready = 1'b0;
    b = B_BASIC; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("bp_b_only_slots", 64'({a_ready, b_ready}), 64'({3'b111, 3'b000}));
    repeat (7) @(posedge clk);
    #1;
    a = A_BASIC; a_acc = 1'b0; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    push_exp(A_BASIC, B_BASIC, 1'b0);
    wait_all("bp");
    a = A_SAT; a_acc = 1'b1; a_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_flags", 64'({result_valid, a_ready, b_ready}), 64'({3'b111, 6'b0}));
      for (int d = 0; d < ND; d++)
        check($sformatf("bp_hold_out%0d", d), 64'({result[d], dot[d], error[d]}),
              64'({40'h50_40_30_20_10, 16'h00F0, 1'b0}));
    end
    a_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_flags", 64'({result_valid, a_ready, b_ready}), 64'({3'b000, 3'b111, 3'b111}));

    // Reset during the second CALC cycle aborts without output and clears the accumulator.
    send(A_BASIC, B_BASIC, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_flags", 64'({result_valid, error, a_ready, b_ready}), 64'({6'b0, 3'b111, 3'b111}));
    for (int d = 0; d < ND; d++) check($sformatf("midrst_dot%0d", d), 64'(dot[d]), 64'd0);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      void'(sb[d].pop_back());
      model_acc[d] = 0;
    end
    send(A_BASIC, B_BASIC, 1'b1);
    wait_all("post_rst");
    check("post_rst_dot", 64'(snap_dot[0]), 64'h00F0);
    check("post_rst_result_t2", 64'(snap_res[1]), 64'h50_40_30_20_10);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) check($sformatf("sb_drained%0d", d), 64'(sb[d].size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
